// File: rtl/conv_to_montgomery.sv
// Maps a conventional residue into the Montgomery domain, y = a * 2^m_size mod m,
// by repeated conditional doubling (PBITS doublings per clock, no multiplier).
// Latency: done_irq_p in the cycle after edge k+2 (k = ceil(m_size/PBITS)), or edge 2 for illegal inputs.
// Backpressure: none; enable_p is accepted only when idle and is dropped otherwise.
module conv_to_montgomery #(
    parameter int NBITS = 2048,
    parameter int PBITS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable_p,
    input  logic [NBITS-1:0]           a,
    input  logic [NBITS-1:0]           m,
    input  logic [$clog2(NBITS)+2:0]   m_size,
    output logic [NBITS-1:0]           y,
    output logic                       err,
    output logic                       busy,
    output logic                       done_irq_p
);
    localparam int MSW = $clog2(NBITS) + 3;

    typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic               start_q;
    logic               accept;
    logic [NBITS-1:0]   a_r, m_r;
    logic [MSW-1:0]     ms_r;
    logic [MSW-1:0]     rem_q;
    logic [MSW-1:0]     step;
    logic               last;
    logic               legal;
    logic [NBITS:0]     x_q, x_d;
    logic [NBITS+1:0]   t, t_sub;

    // start_q gives the wide legality compare a full cycle on registered operands
    assign accept = enable_p && (state_q == IDLE) && !start_q;

    assign legal = m_r[0]
                && (ms_r != '0)
                && (ms_r <= MSW'(NBITS))
                && ((m_r >> ms_r) == '0)
                && (a_r < m_r);

    assign step = (rem_q >= MSW'(PBITS)) ? MSW'(PBITS) : rem_q;
    assign last = (rem_q <= MSW'(PBITS));

    // Chained doubling stages; stages past the remaining count pass x through untouched
    always_comb begin
        x_d   = x_q;
        t     = '0;
        t_sub = '0;
        for (int i = 0; i < PBITS; i++) begin
            if (MSW'(i) < rem_q) begin
                t     = {x_d, 1'b0};
                t_sub = t - {2'b00, m_r};
                x_d   = (t >= {2'b00, m_r}) ? t_sub[NBITS:0] : t[NBITS:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        done_irq_p = 1'b0;
        busy       = (state_q != IDLE);
        case (state_q)
            IDLE:  if (start_q) state_d = CHECK;
            CHECK: state_d = legal ? RUN : DONE;
            RUN:   if (last) state_d = DONE;
            DONE: begin
                done_irq_p = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            y       <= '0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= accept;
            if ((state_q == CHECK) && !legal) begin
                y   <= '0;
                err <= 1'b1;
            end else if ((state_q == RUN) && last) begin
                y   <= x_d[NBITS-1:0];
                err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_r  <= a;
            m_r  <= m;
            ms_r <= m_size;
        end
        if (state_q == CHECK) begin
            x_q   <= {1'b0, a_r};
            rem_q <= ms_r;
        end else if (state_q == RUN) begin
            x_q   <= x_d;
            rem_q <= rem_q - step;
        end
    end

endmodule
